// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding and default
// starvation limit for debug requests.
package dmem_arb_pkg;

  localparam logic [1:0] S_CPU  = 2'd0;
  localparam logic [1:0] S_DBG  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam int DEFAULT_STARVE_LIMIT = 4;
  localparam int WAIT_WIDTH           = 4;

endpackage

// File: rtl/starve_counter.sv
// Saturating wait counter that flags when a debug request has waited
// LIMIT-1 cycles behind the CPU.
module starve_counter
  import dmem_arb_pkg::*;
#(
  parameter int LIMIT = DEFAULT_STARVE_LIMIT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic hit
);

  localparam logic [WAIT_WIDTH-1:0] HIT_VALUE = WAIT_WIDTH'(LIMIT - 1);
  localparam logic [WAIT_WIDTH-1:0] MAX_VALUE = {WAIT_WIDTH{1'b1}};

  logic [WAIT_WIDTH-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != MAX_VALUE)) begin
      count <= count + 1'b1;
    end
  end

  assign hit = (count == HIT_VALUE);

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter between the CPU M-stage and a debug port;
// the CPU wins ties until the debug request has been starved long enough.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_stall,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_wdata,
  output logic                  dbg_ack,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  logic [1:0] state;
  logic [1:0] state_next;
  logic       starve_hit;
  logic       grant;
  logic       dbg_owns;

  always_comb begin
    state_next = state;
    case (state)
      S_CPU:   if (dbg_req && (!cpu_req || starve_hit)) state_next = S_DBG;
      S_DBG:   state_next = S_RESP;
      S_RESP:  state_next = S_CPU;
      default: state_next = S_CPU;
    endcase
  end

  assign grant = (state == S_CPU) && (state_next == S_DBG);

  starve_counter #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve_counter (
    .clk   (clk),
    .reset (reset),
    .clear (!dbg_req || grant),
    .inc   ((state == S_CPU) && dbg_req && cpu_req && !grant),
    .hit   (starve_hit)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_CPU;
    end else begin
      state <= state_next;
    end
  end

  // Ack and read data are registered on the S_DBG -> S_RESP edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dbg_ack   <= 1'b0;
      dbg_rdata <= '0;
    end else begin
      dbg_ack <= (state == S_DBG);
      if ((state == S_DBG) && !dbg_we) begin
        dbg_rdata <= mem_rdata;
      end
    end
  end

  assign dbg_owns  = (state == S_DBG);
  assign mem_addr  = dbg_owns ? dbg_addr  : cpu_addr;
  assign mem_wdata = dbg_owns ? dbg_wdata : cpu_wdata;
  assign mem_we    = dbg_owns ? dbg_we    : (cpu_req & cpu_we);
  assign cpu_rdata = mem_rdata;
  assign cpu_stall = dbg_owns & cpu_req;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic checked
// against a cycle-level reference model and a shadow memory.
module tb_dmem_arbiter;

  localparam int L = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
  logic [31:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        cpu_stall, dbg_ack, mem_we;

  logic [31:0] env_mem [256];
  logic        pre_we = 1'b0;
  logic [7:0]  pre_idx = 8'd0;
  logic [31:0] pre_data = 32'd0;
  int          wr_count = 0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .ADDR_WIDTH   (32),
    .DATA_WIDTH   (32),
    .STARVE_LIMIT (L)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .dbg_req   (dbg_req),
    .dbg_we    (dbg_we),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata),
    .dbg_ack   (dbg_ack),
    .dbg_rdata (dbg_rdata),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  assign mem_rdata = env_mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (pre_we) begin
      env_mem[pre_idx] <= pre_data;
    end else if (mem_we) begin
      env_mem[mem_addr[9:2]] <= mem_wdata;
      wr_count <= wr_count + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] idx, input logic [31:0] data);
    pre_idx  = idx;
    pre_data = data;
    pre_we   = 1'b1;
    tick();
    pre_we   = 1'b0;
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
    dbg_req = 0; dbg_we = 0; dbg_addr = 32'h0; dbg_wdata = 32'h0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h44; cpu_wdata = 32'h55; dbg_req = 1;
    tick(); tick();
    n_checks++; if (dbg_ack !== 1'b0) begin n_errors++; $display("FAIL reset_ack got=%b exp=0", dbg_ack); end
    n_checks++; if (dbg_rdata !== 32'h0) begin n_errors++; $display("FAIL reset_rdata got=%h exp=0", dbg_rdata); end
    n_checks++; if (cpu_stall !== 1'b0) begin n_errors++; $display("FAIL reset_stall got=%b exp=0", cpu_stall); end
    n_checks++; if (mem_addr !== 32'h44 || mem_we !== 1'b1 || mem_wdata !== 32'h55) begin
      n_errors++; $display("FAIL reset_map got addr=%h we=%b wd=%h exp addr=44 we=1 wd=55", mem_addr, mem_we, mem_wdata);
    end
    idle_inputs();
    reset = 1'b1;
    tick();
    $display("txn reset: done");
  endtask

  task automatic test_idle_read();
    preload(8'd16, 32'hDEADBEEF);
    cpu_req = 0; cpu_addr = 32'h10;
    dbg_req = 1; dbg_we = 0; dbg_addr = 32'h40;
    #1;
    n_checks++; if (mem_addr !== 32'h10) begin n_errors++; $display("FAIL idle_pregrant_addr got=%h exp=10", mem_addr); end
    tick();
    n_checks++; if (mem_addr !== 32'h40 || mem_we !== 1'b0) begin
      n_errors++; $display("FAIL idle_dbg_map got addr=%h we=%b exp addr=40 we=0", mem_addr, mem_we);
    end
    n_checks++; if (cpu_stall !== 1'b0 || dbg_ack !== 1'b0) begin
      n_errors++; $display("FAIL idle_dbg_cycle got stall=%b ack=%b exp 0 0", cpu_stall, dbg_ack);
    end
    n_checks++; if (cpu_rdata !== 32'hDEADBEEF) begin n_errors++; $display("FAIL idle_cpu_rdata got=%h exp=deadbeef", cpu_rdata); end
    tick();
    n_checks++; if (dbg_ack !== 1'b1 || dbg_rdata !== 32'hDEADBEEF) begin
      n_errors++; $display("FAIL idle_ack got ack=%b rdata=%h exp ack=1 rdata=deadbeef", dbg_ack, dbg_rdata);
    end
    dbg_req = 0;
    tick();
    n_checks++; if (dbg_ack !== 1'b0 || dbg_rdata !== 32'hDEADBEEF) begin
      n_errors++; $display("FAIL idle_after got ack=%b rdata=%h exp ack=0 rdata=deadbeef", dbg_ack, dbg_rdata);
    end
    $display("txn idle_read: addr=40 rdata=%h", dbg_rdata);
  endtask

  task automatic test_starve();
    int stall_n = 0;
    int grant_k = -1;
    int ack_k = -1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h0;
    dbg_req = 1; dbg_we = 1; dbg_addr = 32'h30; dbg_wdata = 32'h77;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (cpu_stall) begin stall_n++; grant_k = k; end
      if (dbg_ack) begin ack_k = k; dbg_req = 0; end
      tick();
    end
    cpu_req = 0;
    n_checks++; if (stall_n != 1) begin n_errors++; $display("FAIL starve_stall_count got=%0d exp=1", stall_n); end
    n_checks++; if (grant_k != L) begin n_errors++; $display("FAIL starve_grant_cycle got=%0d exp=%0d", grant_k, L); end
    n_checks++; if (ack_k != L + 1) begin n_errors++; $display("FAIL starve_ack_cycle got=%0d exp=%0d", ack_k, L + 1); end
    $display("txn starve: grant=%0d ack=%0d", grant_k, ack_k);
  endtask

  task automatic test_same_cycle_write();
    int base;
    base = wr_count;
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h84; cpu_wdata = 32'hAA;
    dbg_req = 1; dbg_we = 1; dbg_addr = 32'h80; dbg_wdata = 32'h12345678;
    #1;
    n_checks++; if (mem_addr !== 32'h84 || mem_wdata !== 32'hAA || mem_we !== 1'b1 || cpu_stall !== 1'b0) begin
      n_errors++; $display("FAIL same_cpu_first got addr=%h wd=%h we=%b stall=%b", mem_addr, mem_wdata, mem_we, cpu_stall);
    end
    tick();
    cpu_req = 0; cpu_we = 0;
    #1;
    n_checks++; if (env_mem[33] !== 32'hAA || env_mem[32] === 32'h12345678) begin
      n_errors++; $display("FAIL same_order got m84=%h m80=%h exp m84=aa m80 unwritten", env_mem[33], env_mem[32]);
    end
    tick();
    n_checks++; if (mem_addr !== 32'h80 || mem_wdata !== 32'h12345678 || mem_we !== 1'b1) begin
      n_errors++; $display("FAIL same_dbg_map got addr=%h wd=%h we=%b", mem_addr, mem_wdata, mem_we);
    end
    tick();
    n_checks++; if (dbg_ack !== 1'b1) begin n_errors++; $display("FAIL same_ack got=%b exp=1", dbg_ack); end
    dbg_req = 0;
    tick();
    n_checks++; if (env_mem[32] !== 32'h12345678 || env_mem[33] !== 32'hAA || (wr_count - base) != 2) begin
      n_errors++; $display("FAIL same_final got m80=%h m84=%h writes=%0d exp 12345678 aa 2", env_mem[32], env_mem[33], wr_count - base);
    end
    $display("txn same_cycle_write: writes=%0d", wr_count - base);
  endtask

  task automatic test_hold_through_resp();
    logic [5:0] ack_mask = '0;
    logic [5:0] dbg_mask = '0;
    cpu_req = 0; cpu_addr = 32'h4;
    dbg_req = 1; dbg_we = 0; dbg_addr = 32'h40;
    for (int k = 0; k < 6; k++) begin
      #1;
      ack_mask[k] = dbg_ack;
      dbg_mask[k] = (mem_addr == 32'h40);
      tick();
    end
    dbg_req = 0;
    n_checks++; if (ack_mask !== 6'b100100) begin n_errors++; $display("FAIL hold_ack_pattern got=%b exp=100100", ack_mask); end
    n_checks++; if (dbg_mask !== 6'b010010) begin n_errors++; $display("FAIL hold_grant_pattern got=%b exp=010010", dbg_mask); end
    tick();
    $display("txn hold_through_resp: acks=%b", ack_mask);
  endtask

  task automatic test_reset_abort();
    cpu_req = 0; cpu_addr = 32'h8;
    dbg_req = 1; dbg_we = 0; dbg_addr = 32'h40;
    tick();
    cpu_req = 1;
    #1;
    n_checks++; if (cpu_stall !== 1'b1 || mem_addr !== 32'h40) begin
      n_errors++; $display("FAIL abort_in_dbg got stall=%b addr=%h exp 1 40", cpu_stall, mem_addr);
    end
    reset = 1'b0;
    #1;
    n_checks++; if (dbg_ack !== 1'b0 || dbg_rdata !== 32'h0 || cpu_stall !== 1'b0 || mem_addr !== 32'h8) begin
      n_errors++; $display("FAIL abort_async got ack=%b rdata=%h stall=%b addr=%h exp 0 0 0 8", dbg_ack, dbg_rdata, cpu_stall, mem_addr);
    end
    cpu_req = 0;
    tick();
    n_checks++; if (dbg_ack !== 1'b0) begin n_errors++; $display("FAIL abort_no_ack got=%b exp=0", dbg_ack); end
    reset = 1'b1;
    tick();
    n_checks++; if (dbg_ack !== 1'b0 || mem_addr !== 32'h40) begin
      n_errors++; $display("FAIL abort_regrant got ack=%b addr=%h exp 0 40", dbg_ack, mem_addr);
    end
    tick();
    n_checks++; if (dbg_ack !== 1'b1 || dbg_rdata !== 32'hDEADBEEF) begin
      n_errors++; $display("FAIL abort_complete got ack=%b rdata=%h exp 1 deadbeef", dbg_ack, dbg_rdata);
    end
    dbg_req = 0;
    tick();
    $display("txn reset_abort: rdata=%h", dbg_rdata);
  endtask

  task automatic test_random();
    logic [31:0] shadow [256];
    logic [31:0] exp_rdata, exp_addr, exp_wd;
    logic        exp_we, exp_stall;
    int          m_dbg, m_resp, m_wait, pend, txn;
    bit          dropped;
    idle_inputs();
    for (int i = 0; i < 16; i++) begin
      shadow[i] = $urandom;
      preload(8'(i), shadow[i]);
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    exp_rdata = 32'h0; m_dbg = 0; m_resp = 0; m_wait = 0; pend = 0; txn = 0;
    for (int c = 0; c < 600; c++) begin
      dropped = 0;
      n_checks++; if (dbg_ack !== m_resp[0]) begin n_errors++; $display("FAIL rand_ack c=%0d got=%b exp=%0d", c, dbg_ack, m_resp); end
      n_checks++; if (dbg_rdata !== exp_rdata) begin n_errors++; $display("FAIL rand_rdata c=%0d got=%h exp=%h", c, dbg_rdata, exp_rdata); end
      if (dbg_req) pend++;
      if (dbg_req && m_resp != 0) begin
        txn++;
        $display("txn rand %0d: %s addr=%h latency=%0d", txn, dbg_we ? "write" : "read", dbg_addr, pend);
        n_checks++; if (pend > L + 2) begin n_errors++; $display("FAIL rand_latency got=%0d max=%0d", pend, L + 2); end
        dbg_req = 0;
        dropped = 1;
      end
      cpu_req   = ($urandom_range(0, 7) != 0);
      cpu_we    = 1'($urandom_range(0, 1));
      cpu_addr  = 32'($urandom_range(0, 15)) << 2;
      cpu_wdata = $urandom;
      if (!dbg_req && !dropped && $urandom_range(0, 3) == 0) begin
        dbg_req   = 1;
        dbg_we    = 1'($urandom_range(0, 1));
        dbg_addr  = 32'($urandom_range(0, 15)) << 2;
        dbg_wdata = $urandom;
        pend      = 0;
      end
      #1;
      exp_addr  = (m_dbg != 0) ? dbg_addr  : cpu_addr;
      exp_wd    = (m_dbg != 0) ? dbg_wdata : cpu_wdata;
      exp_we    = (m_dbg != 0) ? dbg_we    : (cpu_req & cpu_we);
      exp_stall = (m_dbg != 0) && cpu_req;
      n_checks++; if (mem_addr !== exp_addr || mem_we !== exp_we || (exp_we && mem_wdata !== exp_wd)) begin
        n_errors++; $display("FAIL rand_port c=%0d got addr=%h we=%b wd=%h exp addr=%h we=%b wd=%h", c, mem_addr, mem_we, mem_wdata, exp_addr, exp_we, exp_wd);
      end
      n_checks++; if (cpu_stall !== exp_stall) begin n_errors++; $display("FAIL rand_stall c=%0d got=%b exp=%b", c, cpu_stall, exp_stall); end
      n_checks++; if (cpu_rdata !== shadow[exp_addr[9:2]]) begin
        n_errors++; $display("FAIL rand_cpu_rdata c=%0d got=%h exp=%h", c, cpu_rdata, shadow[exp_addr[9:2]]);
      end
      // Advance the model by one memory cycle.
      if (m_dbg != 0 && !dbg_we) exp_rdata = shadow[dbg_addr[9:2]];
      if (exp_we) shadow[exp_addr[9:2]] = exp_wd;
      if (m_dbg != 0) begin
        m_dbg = 0; m_resp = 1;
      end else if (m_resp != 0) begin
        m_resp = 0;
      end else if (dbg_req && (!cpu_req || m_wait == L - 1)) begin
        m_dbg = 1; m_wait = 0;
      end else if (dbg_req) begin
        m_wait++;
      end else begin
        m_wait = 0;
      end
      tick();
    end
    idle_inputs();
    $display("txn random: %0d debug transactions", txn);
  endtask

  initial begin
    test_reset();
    test_idle_read();
    test_starve();
    test_same_cycle_write();
    test_hold_through_resp();
    test_reset_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, 32, memory address width; DATA_WIDTH, 32, data width; STARVE_LIMIT, 4, maximum consecutive cycles a debug request may wait while the CPU holds the port (legal range 1..15).
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 The ports SHALL be:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low
- cpu_req  in  1  CPU M-stage access this cycle
- cpu_we  in  1  CPU store
- cpu_addr  in  ADDR_WIDTH  CPU address
- cpu_wdata  in  DATA_WIDTH  CPU store data
- cpu_rdata  out  DATA_WIDTH  CPU load data (combinational)
- cpu_stall  out  1  hold the CPU pipeline
- dbg_req  in  1  debug access, held until ack
- dbg_we  in  1  debug write
- dbg_addr  in  ADDR_WIDTH  debug address
- dbg_wdata  in  DATA_WIDTH  debug write data
- dbg_ack  out  1  one-cycle completion pulse
- dbg_rdata  out  DATA_WIDTH  registered debug read data
- mem_we  out  1  to data memory
- mem_addr  out  ADDR_WIDTH  to data memory
- mem_wdata  out  DATA_WIDTH  to data memory
- mem_rdata  in  DATA_WIDTH  from data memory (combinational read)

Function
REQ-004 The FSM SHALL have three states: S_CPU (reset state), S_DBG and S_RESP.
REQ-005 In S_CPU and S_RESP the CPU SHALL own the port:
- mem_addr=cpu_addr, mem_wdata=cpu_wdata
- mem_we=cpu_req&cpu_we
REQ-006 In S_DBG the debug port SHALL own the port:
- mem_addr=dbg_addr, mem_wdata=dbg_wdata
- mem_we=dbg_we
REQ-007 cpu_rdata SHALL equal mem_rdata in all states.
REQ-008 cpu_stall SHALL equal (state==S_DBG)&cpu_req, with no other stall source.
REQ-009 From S_CPU the FSM SHALL go to S_DBG when dbg_req && (!cpu_req || wait_cnt==STARVE_LIMIT-1), and SHALL otherwise stay in S_CPU.
REQ-010 From S_DBG the FSM SHALL unconditionally go to S_RESP after one cycle, and the debug access SHALL therefore occupy exactly one memory cycle.
REQ-011 From S_RESP the FSM SHALL unconditionally go to S_CPU. dbg_req seen in S_RESP SHALL be ignored.
REQ-012 wait_cnt (4 bits) SHALL:
- increment in S_CPU when dbg_req&cpu_req and no transition occurs
- clear on entry to S_DBG
- clear whenever dbg_req=0
- never wrap
REQ-013 dbg_rdata SHALL capture mem_rdata on the S_DBG->S_RESP edge when dbg_we=0, and SHALL otherwise hold its value.
REQ-014 dbg_ack SHALL be 1 only in S_DBG->S_RESP registered form, i.e. high for exactly the S_RESP cycle, so the latency from grant to ack is 1 cycle.
REQ-015 Worst-case debug latency from dbg_req rise to dbg_ack SHALL be STARVE_LIMIT+2 cycles.
REQ-016 Simultaneous cpu_req and dbg_req with wait_cnt<STARVE_LIMIT-1 SHALL be granted to the CPU.
REQ-017 A CPU store during S_DBG SHALL NOT reach memory, because it is stalled and re-presented by the pipeline.

Reset
REQ-018 Asserting reset (low) at any time SHALL asynchronously force:
- state=S_CPU
- wait_cnt=0
- dbg_ack=0
- dbg_rdata=0
REQ-019 During reset, combinational outputs SHALL follow the S_CPU mapping.
REQ-020 An in-flight debug access aborted by reset SHALL NOT be acknowledged; a dbg_req still held after release SHALL be re-arbitrated from S_CPU.

Structure
REQ-021 The shared package dmem_arb_pkg SHALL hold:
- the state encoding (S_CPU=2'd0, S_DBG=2'd1, S_RESP=2'd2)
- the default STARVE_LIMIT
REQ-022 The saturating wait counter SHALL be the single sub-module starve_counter (clear, inc, limit-hit output).
REQ-023 All output muxing SHALL be combinational from state, and all other state SHALL be registered on the clk rising edge.

Verification
REQ-024 Idle CPU, dbg read addr 0x40 (mem holds 0xDEADBEEF) -> S_DBG next cycle, dbg_ack one cycle later, dbg_rdata=0xDEADBEEF, cpu_stall never high.
REQ-025 cpu_req held high continuously, dbg_req rises at cycle 0 -> grant at cycle STARVE_LIMIT (4), cpu_stall high exactly 1 cycle, dbg_ack at cycle 5.
REQ-026 dbg write 0x12345678 to 0x80 while the CPU stores 0xAA to 0x84 in the same cycle -> CPU store commits first; after ack, mem[0x80]=0x12345678 and mem[0x84]=0xAA, with no lost or duplicated write.
REQ-027 reset pulled low during S_DBG -> dbg_ack stays 0, dbg_rdata=0, state S_CPU; with dbg_req still high after release, the access completes normally.
REQ-028 dbg_req held high through S_RESP -> no second grant in S_RESP; the next grant follows normal S_CPU rules.
